// File: rtl/alu_pipe_pkg.sv
// Shared opcode map, FSM state type and sizing helper for alu_pipe.
package alu_pipe_pkg;

  // Opcode groups (alu_code[4:3])
  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  // Full opcodes
  localparam logic [4:0] OP_ADD  = {GRP_ARITH, 3'b000};
  localparam logic [4:0] OP_ADDU = {GRP_ARITH, 3'b001};
  localparam logic [4:0] OP_SUB  = {GRP_ARITH, 3'b010};
  localparam logic [4:0] OP_SUBU = {GRP_ARITH, 3'b011};
  localparam logic [4:0] OP_AND  = {GRP_LOGIC, 3'b000};
  localparam logic [4:0] OP_OR   = {GRP_LOGIC, 3'b001};
  localparam logic [4:0] OP_XOR  = {GRP_LOGIC, 3'b010};
  localparam logic [4:0] OP_NOT  = {GRP_LOGIC, 3'b100};
  localparam logic [4:0] OP_SLL  = {GRP_SHIFT, 3'b000};
  localparam logic [4:0] OP_SRL  = {GRP_SHIFT, 3'b001};
  localparam logic [4:0] OP_SLA  = {GRP_SHIFT, 3'b010};
  localparam logic [4:0] OP_SRA  = {GRP_SHIFT, 3'b011};
  localparam logic [4:0] OP_LE   = {GRP_CMP,   3'b000};
  localparam logic [4:0] OP_LT   = {GRP_CMP,   3'b001};
  localparam logic [4:0] OP_GE   = {GRP_CMP,   3'b010};
  localparam logic [4:0] OP_GT   = {GRP_CMP,   3'b011};
  localparam logic [4:0] OP_EQ   = {GRP_CMP,   3'b100};
  localparam logic [4:0] OP_NE   = {GRP_CMP,   3'b101};

  typedef enum logic {IDLE, SHIFT} state_t;

  // Width of the shift-amount field taken from b
  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum, carry (add) or borrow (sub), signed overflow, zero.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] b_eff;
  logic             cout;

  // A + B, or A + ~B + 1 for subtraction; borrow is the inverted carry
  always_comb begin
    b_eff       = sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    carry       = sub ? ~cout : cout;
    ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    zero        = (sum == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, optional serial shifter and sticky overflow.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             overflow,
  output logic             illegal,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  localparam int SW = shamt_width(WIDTH);

  state_t           state, state_d;
  logic [SW-1:0]    amt, cnt;
  logic [WIDTH-1:0] work, work_nx;
  logic [1:0]       sop;
  logic             sla_acc, step_ovf;
  logic             accept, is_shift, start_serial, finish;

  logic [WIDTH-1:0] as_sum;
  logic             as_sub, as_carry, as_ovf, as_zero;

  logic [WIDTH-1:0] res, sll;
  logic [WIDTH-2:0] sla_diff;
  logic             res_ovf, res_ill, lt, sla_ovf;

  assign amt      = b[SW-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_shift = (alu_code[4:3] == GRP_SHIFT) && !alu_code[2];
  assign as_sub   = (alu_code == OP_SUB) || (alu_code == OP_SUBU) || (alu_code[4:3] == GRP_CMP);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (a),
    .b     (b),
    .sub   (as_sub),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf),
    .zero  (as_zero)
  );

  // Single-cycle result: everything except serial shifts with a non-zero amount
  always_comb begin
    res      = '0;
    res_ovf  = 1'b0;
    res_ill  = 1'b0;
    lt       = as_sum[WIDTH-1] ^ as_ovf;
    sll      = a << amt;
    // SLA overflows when any of the top amt bits below the sign differ from it
    sla_diff = a[WIDTH-2:0] ^ {(WIDTH-1){a[WIDTH-1]}};
    sla_ovf  = |(sla_diff & ~({(WIDTH-1){1'b1}} >> amt));
    case (alu_code)
      OP_ADD, OP_SUB:   begin res = as_sum; res_ovf = as_ovf;   end
      OP_ADDU, OP_SUBU: begin res = as_sum; res_ovf = as_carry; end
      OP_AND:           res = a & b;
      OP_OR:            res = a | b;
      OP_XOR:           res = a ^ b;
      OP_NOT:           res = ~a;
      OP_SLL:           res = sll;
      OP_SRL:           res = a >> amt;
      OP_SLA:           begin res = {a[WIDTH-1], sll[WIDTH-2:0]}; res_ovf = sla_ovf; end
      OP_SRA:           res = WIDTH'($signed(a) >>> amt);
      OP_LE:            res[0] = lt || as_zero;
      OP_LT:            res[0] = lt;
      OP_GE:            res[0] = !lt;
      OP_GT:            res[0] = !lt && !as_zero;
      OP_EQ:            res[0] = as_zero;
      OP_NE:            res[0] = !as_zero;
      default:          res_ill = 1'b1;
    endcase
  end

  // One-bit step of the serial shifter for the captured shift sub-op
  always_comb begin
    work_nx  = work;
    step_ovf = work[WIDTH-2] ^ work[WIDTH-1];
    case (sop)
      2'b00: work_nx = work << 1;
      2'b01: work_nx = work >> 1;
      2'b10: work_nx = {work[WIDTH-1], work[WIDTH-3:0], 1'b0};
      2'b11: work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_nx = work;
    endcase
  end

  // FSM next state
  always_comb begin
    state_d      = state;
    start_serial = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE:
        if (accept && is_shift && SERIAL_SHIFT && (amt != '0)) begin
          state_d      = SHIFT;
          start_serial = 1'b1;
        end
      SHIFT:
        if (cnt == SW'(1)) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Result/handshake registers and serial shift datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      sop       <= '0;
      sla_acc   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !start_serial) begin
        c         <= res;
        overflow  <= res_ovf;
        illegal   <= res_ill;
        out_valid <= 1'b1;
      end
      if (start_serial) begin
        work    <= a;
        cnt     <= amt;
        sop     <= alu_code[1:0];
        sla_acc <= 1'b0;
      end
      if (state == SHIFT) begin
        work    <= work_nx;
        cnt     <= cnt - SW'(1);
        sla_acc <= sla_acc | step_ovf;
        // Final step writes the shifted value straight into the result register
        if (finish) begin
          c         <= work_nx;
          overflow  <= (sop == 2'b10) && (sla_acc || step_ovf);
          illegal   <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

  // Sticky overflow: a delivered overflow result wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               sticky_ovf <= 1'b0;
    else if (out_valid && out_ready && overflow) sticky_ovf <= 1'b1;
    else if (clr_sticky)                      sticky_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: 16-bit serial-shift and 32-bit barrel-shift instances.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, clr_sticky, sel32;
  logic [31:0] a, b;
  logic [4:0]  code;

  logic        rdy16, val16, ovf16, ill16, st16;
  logic [15:0] c16;
  logic        rdy32, val32, ovf32, ill32, st32;
  logic [31:0] c32;
  logic        iv16, iv32;

  logic        o_ready, o_valid, o_ovf, o_ill, o_sticky;
  logic [31:0] o_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv16     = in_valid && !sel32;
  assign iv32     = in_valid && sel32;
  assign o_ready  = sel32 ? rdy32 : rdy16;
  assign o_valid  = sel32 ? val32 : val16;
  assign o_c      = sel32 ? c32 : {16'h0000, c16};
  assign o_ovf    = sel32 ? ovf32 : ovf16;
  assign o_ill    = sel32 ? ill32 : ill16;
  assign o_sticky = sel32 ? st32 : st16;

  alu_pipe #(.WIDTH(16), .SERIAL_SHIFT(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
    .a(a[15:0]), .b(b[15:0]), .alu_code(code), .out_valid(val16),
    .out_ready(out_ready), .c(c16), .overflow(ovf16), .illegal(ill16),
    .sticky_ovf(st16), .clr_sticky(clr_sticky)
  );

  alu_pipe #(.WIDTH(32), .SERIAL_SHIFT(1'b0)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32),
    .a(a), .b(b), .alu_code(code), .out_valid(val32),
    .out_ready(out_ready), .c(c32), .overflow(ovf32), .illegal(ill32),
    .sticky_ovf(st32), .clr_sticky(clr_sticky)
  );

  // Reference model in plain integer arithmetic; lat = cycles spent shifting after acceptance
  function automatic void model(input int w, input bit serial, input logic [31:0] ia,
                                input logic [31:0] ib, input logic [4:0] op,
                                output logic [31:0] rc, output logic rov, output logic ril,
                                output int lat);
    longint mask, ua, ub, sa, sb, r, maxv, minv;
    int n;
    mask = (longint'(1) << w) - 1;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    ua = longint'(ia) & mask;
    ub = longint'(ib) & mask;
    sa = ia[w-1] ? ua - (longint'(1) << w) : ua;
    sb = ib[w-1] ? ub - (longint'(1) << w) : ub;
    n  = int'(ub) & (w - 1);
    r = 0; rov = 1'b0; ril = 1'b0;
    case (op)
      5'b00000: begin r = sa + sb; rov = (r > maxv) || (r < minv); end
      5'b00001: begin r = ua + ub; rov = r > mask; end
      5'b00010: begin r = sa - sb; rov = (r > maxv) || (r < minv); end
      5'b00011: begin r = ua - ub; rov = ua < ub; end
      5'b01000: r = ua & ub;
      5'b01001: r = ua | ub;
      5'b01010: r = ua ^ ub;
      5'b01100: r = ~ua;
      5'b10000: r = ua << n;
      5'b10001: r = ua >> n;
      5'b10010: begin
        r   = sa <<< n;
        rov = (r > maxv) || (r < minv);
        r   = (ua & (longint'(1) << (w - 1))) | (r & (mask >> 1));
      end
      5'b10011: r = sa >>> n;
      5'b11000: r = (sa <= sb) ? 1 : 0;
      5'b11001: r = (sa <  sb) ? 1 : 0;
      5'b11010: r = (sa >= sb) ? 1 : 0;
      5'b11011: r = (sa >  sb) ? 1 : 0;
      5'b11100: r = (sa == sb) ? 1 : 0;
      5'b11101: r = (sa != sb) ? 1 : 0;
      default:  ril = 1'b1;
    endcase
    rc  = 32'(r & mask);
    lat = (serial && (op[4:2] == 3'b100) && (n != 0)) ? n : 0;
  endfunction

  // Issue one op with out_ready=1; returns at the negedge where out_valid is first seen
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic [4:0] tc,
                        output logic [31:0] oc, output logic oo, output logic oi,
                        output int lat, output int busy);
    int g;
    a = ta; b = tb2; code = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    g = 0;
    while (!o_ready && g < 100) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; busy = 0;
    while (!o_valid && lat < 100) begin
      if (!o_ready) busy++;
      @(negedge clk);
      lat++;
    end
    oc = o_c; oo = o_ovf; oi = o_ill;
    if (!o_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] oc; logic oo, oi; int lat, busy;
    sel32 = 1'b0;
    run_op(32'h7FFF, 32'h0001, 5'b00000, oc, oo, oi, lat, busy);
    @(negedge clk);
    checks++; if (o_sticky !== 1'b1) begin errors++; $display("FAIL pre_reset_sticky got %b exp 1", o_sticky); end
    out_ready = 1'b0; a = 32'h1; b = 32'h2; code = 5'b00000; in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_held got %b exp 1", o_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", o_valid); end
    checks++; if (o_c !== 32'h0) begin errors++; $display("FAIL reset_c got %h exp 0", o_c); end
    checks++; if (o_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", o_sticky); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", o_ready); end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if ({o_valid, o_ready, o_sticky} !== 3'b010) begin errors++; $display("FAIL post_reset got v/r/s %b exp 010", {o_valid, o_ready, o_sticky}); end
  endtask

  task automatic test_add_sticky();
    logic [31:0] oc; logic oo, oi; int lat, busy;
    drain(); sel32 = 1'b0;
    run_op(32'h7FFF, 32'h0001, 5'b00000, oc, oo, oi, lat, busy);
    checks++; if (oc !== 32'h8000) begin errors++; $display("FAIL add_c got %h exp 8000", oc); end
    checks++; if (oo !== 1'b1) begin errors++; $display("FAIL add_ovf got %b exp 1", oo); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL add_lat got %0d exp 0", lat); end
    @(negedge clk);
    checks++; if (o_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got %b exp 1", o_sticky); end
    clr_sticky = 1'b1; @(negedge clk); clr_sticky = 1'b0;
    checks++; if (o_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr got %b exp 0", o_sticky); end
    run_op(32'h7FFF, 32'h0001, 5'b00000, oc, oo, oi, lat, busy);
    clr_sticky = 1'b1; @(negedge clk); clr_sticky = 1'b0;
    checks++; if (o_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %b exp 1", o_sticky); end
  endtask

  task automatic test_compare();
    logic [31:0] oc; logic oo, oi; int lat, busy;
    sel32 = 1'b0;
    run_op(32'hFFFF, 32'h0001, 5'b11001, oc, oo, oi, lat, busy);
    checks++; if (oc !== 32'h1) begin errors++; $display("FAIL lt_c got %h exp 1", oc); end
    run_op(32'hFFFF, 32'h0001, 5'b11011, oc, oo, oi, lat, busy);
    checks++; if (oc !== 32'h0) begin errors++; $display("FAIL gt_c got %h exp 0", oc); end
    run_op(32'h0001, 32'h0002, 5'b00011, oc, oo, oi, lat, busy);
    checks++; if ({oo, oc} !== {1'b1, 32'hFFFF}) begin errors++; $display("FAIL subu got ovf %b c %h exp ovf 1 c ffff", oo, oc); end
  endtask

  task automatic test_shift();
    logic [31:0] oc; logic oo, oi; int lat, busy;
    sel32 = 1'b0;
    run_op(32'h8000, 32'h0004, 5'b10011, oc, oo, oi, lat, busy);
    checks++; if (oc !== 32'hF800) begin errors++; $display("FAIL sra_c got %h exp f800", oc); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sra_lat got %0d exp 4", lat); end
    checks++; if (busy !== 4) begin errors++; $display("FAIL sra_busy got %0d exp 4", busy); end
    run_op(32'h4001, 32'h0001, 5'b10010, oc, oo, oi, lat, busy);
    checks++; if ({oo, oc} !== {1'b1, 32'h0002}) begin errors++; $display("FAIL sla got ovf %b c %h exp ovf 1 c 0002", oo, oc); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sla_lat got %0d exp 1", lat); end
  endtask

  task automatic test_illegal();
    logic [31:0] oc; logic oo, oi; int lat, busy;
    sel32 = 1'b0;
    run_op(32'h1234, 32'h5678, 5'b01011, oc, oo, oi, lat, busy);
    checks++; if ({oi, oo, oc} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL illegal got ill %b ovf %b c %h exp 1 0 0", oi, oo, oc); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_lat got %0d exp 0", lat); end
  endtask

  task automatic test_hold(input bit s);
    logic [31:0] a1, b1, a2, b2, e1, e2; logic eo, ei; int el, g, w;
    drain(); sel32 = s; w = s ? 32 : 16;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    model(w, !s, a1, b1, 5'b01010, e1, eo, ei, el);
    model(w, !s, a2, b2, 5'b00001, e2, eo, ei, el);
    out_ready = 1'b0; a = a1; b = b1; code = 5'b01010; in_valid = 1'b1;
    #1;
    g = 0;
    while (!o_ready && g < 50) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    a = a2; b = b2; code = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_valid, o_ready, o_c} !== {1'b1, 1'b0, e1}) begin
        errors++; $display("FAIL hold_w%0d got v%b r%b c %h exp v1 r0 c %h", w, o_valid, o_ready, o_c, e1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready_w%0d got %b exp 1", w, o_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({o_valid, o_c} !== {1'b1, e2}) begin errors++; $display("FAIL hold_next_w%0d got v%b c %h exp v1 c %h", w, o_valid, o_c, e2); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hold_drained_w%0d got %b exp 0", w, o_valid); end
  endtask

  task automatic test_random(input bit s, input int iters);
    logic [4:0]  codes [20] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01000,
                                5'b01001, 5'b01010, 5'b01100, 5'b10000, 5'b10001,
                                5'b10010, 5'b10011, 5'b11000, 5'b11001, 5'b11010,
                                5'b11011, 5'b11100, 5'b11101, 5'b01011, 5'b10100};
    logic [31:0] ta, tb2, oc, ec; logic oo, oi, eo, ei; int lat, busy, el, w;
    logic [4:0]  op;
    drain(); sel32 = s; w = s ? 32 : 16;
    for (int i = 0; i < iters; i++) begin
      op = codes[$urandom_range(19)];
      ta = $urandom; tb2 = $urandom;
      if ($urandom_range(3) == 0) ta = s ? 32'h7FFF_FFFF : 32'h0000_7FFF;
      model(w, !s, ta, tb2, op, ec, eo, ei, el);
      run_op(ta, tb2, op, oc, oo, oi, lat, busy);
      checks++;
      if ({oc, oo, oi} !== {ec, eo, ei}) begin
        errors++; $display("FAIL rand_w%0d op %b a %h b %h got c %h ovf %b ill %b exp c %h ovf %b ill %b",
                           w, op, ta, tb2, oc, oo, oi, ec, eo, ei);
      end
      checks++;
      if (lat !== el) begin errors++; $display("FAIL rand_lat_w%0d op %b got %0d exp %0d", w, op, lat, el); end
    end
  endtask

  task automatic test_reset_shift();
    logic [31:0] oc; logic oo, oi; int lat, busy, g, stale;
    drain(); sel32 = 1'b0;
    run_op(32'h0005, 32'h0006, 5'b00000, oc, oo, oi, lat, busy);
    drain();
    a = 32'h8000; b = 32'h000A; code = 5'b10011; in_valid = 1'b1;
    #1;
    g = 0;
    while (!o_ready && g < 50) begin @(negedge clk); #1; g++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({o_valid, o_ready, o_c} !== {1'b0, 1'b0, 32'h000B}) begin errors++; $display("FAIL mid_shift got v%b r%b c %h exp v0 r0 c 000b", o_valid, o_ready, o_c); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_valid, o_ready, o_c, o_ovf, o_ill} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL shift_reset got v%b r%b c %h ovf %b ill %b exp v0 r1 c 0 0 0", o_valid, o_ready, o_c, o_ovf, o_ill);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (20) begin @(negedge clk); if (o_valid) stale++; end
    checks++; if (stale !== 0) begin errors++; $display("FAIL stale_result got %0d valid cycles exp 0", stale); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0; sel32 = 1'b0;
    a = '0; b = '0; code = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_sticky();
    test_compare();
    test_shift();
    test_illegal();
    test_hold(1'b0);
    test_hold(1'b1);
    test_random(1'b0, 80);
    test_random(1'b1, 80);
    test_reset_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
